vdp_super_res_prefetch: RTL and testbench

VDP_SUPER_RES_PREFETCH -- requirements
Module: vdp_super_res_prefetch

---
 rtl/vdp_super_res_prefetch.sv | 135 +++++++++++++
 tb/tb_vdp_super_res_prefetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_res_prefetch.sv
// rtl/vdp_super_res_prefetch.sv - super-res line prefetcher: one SDRAM read in flight, 4-word FIFO
module vdp_super_res_prefetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdp_super,
  input  logic        line_start,
  input  logic [17:0] start_addr,
  input  logic [7:0]  words_per_line,
  input  logic        pop,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        line_done,
  output logic        underrun,
  input  logic        clear_underrun,
  output logic        mem_req,
  output logic [17:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        mem_data_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [17:0] addr, addr_nxt;
  logic [7:0]  remaining, remaining_nxt;
  logic        discard, discard_nxt;
  logic [31:0] fifo_mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        req_fire;
  logic        push;
  logic        do_pop;
  logic        set_underrun;

  // Request is decoded purely from registered state; only one read can be in flight.
  assign mem_req      = (state == REQ) && !discard && (count < 3'd4);
  assign mem_addr     = addr;
  assign line_done    = (state == IDLE) || (state == DONE);
  assign word_valid   = (count != 3'd0);
  assign word_out     = word_valid ? fifo_mem[rd_ptr] : 32'd0;
  assign req_fire     = mem_req && mem_ack;
  assign do_pop       = pop && word_valid && !line_start;
  assign set_underrun = pop && !word_valid && !line_start;

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    discard_nxt   = discard;
    push          = 1'b0;

    case (state)
      REQ: begin
        if (req_fire) begin
          addr_nxt      = addr + 18'd1;
          remaining_nxt = remaining - 8'd1;
          state_nxt     = WAIT;
        end
      end
      WAIT: begin
        if (mem_data_valid && !discard) begin
          push      = 1'b1;
          state_nxt = (remaining != 8'd0) ? REQ : DONE;
        end
      end
      default: ;
    endcase

    if (discard && mem_data_valid) begin
      discard_nxt = 1'b0;
    end

    // A new line abandons the old one; a read still in flight must be swallowed on return.
    if (line_start) begin
      addr_nxt      = start_addr;
      remaining_nxt = words_per_line;
      state_nxt     = (words_per_line == 8'd0) ? DONE : REQ;
      push          = 1'b0;
      discard_nxt   = ((discard || state == WAIT) && !mem_data_valid) || req_fire;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      discard   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      underrun  <= 1'b0;
    end else if (!vdp_super) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      discard   <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      discard   <= discard_nxt;
      if (line_start) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 2'd1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
        count <= count + {2'b00, push} - {2'b00, do_pop};
      end
      if (set_underrun) begin
        underrun <= 1'b1;
      end else if (clear_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && vdp_super) begin
      fifo_mem[wr_ptr] <= mem_data;
    end
  end

endmodule

// File: tb/tb_vdp_super_res_prefetch.sv
// tb/tb_vdp_super_res_prefetch.sv - scoreboard bench with a behavioural SDRAM arbiter model
module tb_vdp_super_res_prefetch;

  logic        clk = 1'b0;
  logic        reset_n, vdp_super, line_start, pop, clear_underrun;
  logic [17:0] start_addr, mem_addr;
  logic [7:0]  words_per_line;
  logic [31:0] word_out, mem_data;
  logic        word_valid, line_done, underrun, mem_req, mem_ack, mem_data_valid;

  always #5 clk = ~clk;

  vdp_super_res_prefetch dut (
    .clk(clk), .reset_n(reset_n), .vdp_super(vdp_super), .line_start(line_start),
    .start_addr(start_addr), .words_per_line(words_per_line), .pop(pop),
    .word_out(word_out), .word_valid(word_valid), .line_done(line_done),
    .underrun(underrun), .clear_underrun(clear_underrun), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .mem_data_valid(mem_data_valid)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [17:0] addr_q[$];

  // arbiter knobs owned by the stimulus process
  int ack_lat = 1, data_lat = 1, inj_req = 0, stray_req = 0;
  // arbiter-owned state
  int inj_done = 0, stray_done = 0, wcnt = 0;
  logic arb_busy = 1'b0;
  logic [17:0] arb_addr = '0;
  // monitor-owned state
  int ncyc = 0, last_dv_neg = -1, last_req_rise = -1, acc_cnt = 0;
  logic prev_req = 1'b0, exp_ur = 1'b0;

  function automatic logic [31:0] memf(input logic [17:0] a);
    return {a[13:0], a} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM arbiter: acks mem_req after ack_lat cycles, returns data data_lat cycles later
  initial begin
    mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = $urandom;
      if (arb_busy) begin
        if (wcnt > 0) wcnt--;
        else begin
          mem_data_valid = 1'b1;
          if (inj_done != inj_req) begin
            mem_data = 32'hDEADBEEF;
            inj_done++;
          end else begin
            mem_data = memf(arb_addr);
          end
          arb_busy = 1'b0;
          wcnt = ack_lat - 1;
        end
      end else if (stray_done != stray_req) begin
        mem_data_valid = 1'b1;
        stray_done++;
      end else if (mem_req) begin
        if (wcnt > 0) wcnt--;
        else begin
          mem_ack = 1'b1;
          arb_busy = 1'b1;
          arb_addr = mem_addr;
          wcnt = data_lat - 1;
        end
      end else begin
        wcnt = ack_lat - 1;
      end
    end
  end

  // monitor: inputs and outputs are both settled at the falling edge
  always @(negedge clk) begin
    ncyc++;
    if (mem_data_valid) last_dv_neg = ncyc;
    if (mem_req && !prev_req) last_req_rise = ncyc;
    prev_req = mem_req;
    if (!reset_n) exp_ur = 1'b0;
    check("underrun", underrun, exp_ur);
    if (reset_n && vdp_super) begin
      check("single_outstanding", mem_req && arb_busy && !mem_ack, 0);
      if (mem_req) check("line_done_busy", line_done, 0);
      if (!line_start && pop && word_valid) begin
        if (exp_q.size() == 0) check("extra_word", word_out, 32'hFFFF_FFFF);
        else check("word", word_out, exp_q.pop_front());
      end
      if (!line_start && mem_req && mem_ack) begin
        acc_cnt++;
        if (addr_q.size() == 0) check("extra_read", 1, 0);
        else check("mem_addr", mem_addr, addr_q.pop_front());
      end
    end
    if (!reset_n || !vdp_super) exp_ur = 1'b0;
    else if (pop && !word_valid && !line_start) exp_ur = 1'b1;
    else if (clear_underrun) exp_ur = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic line_go(input logic [17:0] a, input int n);
    logic [17:0] t;
    exp_q.delete(); addr_q.delete();
    for (int i = 0; i < n; i++) begin
      t = a + 18'(i);
      addr_q.push_back(t);
      exp_q.push_back(memf(t));
    end
    start_addr = a; words_per_line = 8'(n); line_start = 1'b1;
    tick(1);
    line_start = 1'b0; start_addr = 18'($urandom); words_per_line = 8'($urandom);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    pop = 1'b1;
    while (!(line_done && !word_valid) && k < 300) begin tick(1); k++; end
    pop = 1'b0;
    if (k >= 300) check({tag, "_timeout"}, 1, 0);
    check({tag, "_all_words"}, exp_q.size(), 0);
    clear_underrun = 1'b1; tick(1); clear_underrun = 1'b0;
  endtask

  task automatic wait_arb(input logic busy, input string tag);
    int k;
    k = 0;
    while (arb_busy != busy && k < 50) begin tick(1); k++; end
    if (k >= 50) check({tag, "_arb_timeout"}, 1, 0);
  endtask

  initial begin
    int k, n0, dv0, n;
    logic [17:0] a;
    bit aborted;
    reset_n = 1'b0; vdp_super = 1'b1; line_start = 1'b0; pop = 1'b0; clear_underrun = 1'b0;
    start_addr = '0; words_per_line = '0;
    tick(3);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_out", word_out, 0);
    check("rst_line_done", line_done, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset_n = 1'b1;
    tick(5);
    check("idle_no_fetch", mem_req, 0);
    check("idle_line_done", line_done, 1);

    ack_lat = 2; data_lat = 2;
    line_go(18'h00100, 3);
    check("busy_line_done", line_done, 0);
    k = 0;
    while (!line_done && k < 100) begin tick(1); k++; end
    check("l3_done", line_done, 1);
    check("l3_valid", word_valid, 1);
    drain("l3");

    line_go(18'h3FFFF, 2);
    drain("wrap");

    pop = 1'b1; tick(1); pop = 1'b0;
    check("ur_set", underrun, 1);
    check("ur_valid", word_valid, 0);
    pop = 1'b1; clear_underrun = 1'b1; tick(1); pop = 1'b0;
    check("ur_set_beats_clear", underrun, 1);
    tick(1); clear_underrun = 1'b0;
    check("ur_clear", underrun, 0);

    stray_req++;
    tick(4);
    check("stray_ignored", word_valid, 0);

    ack_lat = 1; data_lat = 3;
    n0 = acc_cnt;
    line_go(18'h02000, 8);
    tick(60);
    check("full_reads", acc_cnt - n0, 4);
    check("full_no_req", mem_req, 0);
    pop = 1'b1; tick(1); pop = 1'b0;
    tick(30);
    check("one_more_read", acc_cnt - n0, 5);
    pop = 1'b1; tick(1); pop = 1'b0;
    k = 0;
    while (!mem_data_valid && k < 30) begin tick(1); k++; end
    check("dv_seen", mem_data_valid, 1);
    pop = 1'b1; tick(1); pop = 1'b0;
    tick(30);
    check("pushpop_reads", acc_cnt - n0, 7);
    check("pushpop_no_req", mem_req, 0);
    drain("l8");

    data_lat = 5;
    line_go(18'h00500, 4);
    wait_arb(1'b1, "disc");
    tick(1);
    dv0 = last_dv_neg;
    inj_req++;
    line_go(18'h00600, 2);
    k = 0;
    while (last_dv_neg == dv0 && k < 30) begin tick(1); k++; end
    tick(3);
    check("discard_next_req", last_req_rise - last_dv_neg, 1);
    drain("disc");

    data_lat = 6;
    line_go(18'h00700, 3);
    wait_arb(1'b1, "arst");
    tick(1);
    reset_n = 1'b0; exp_q.delete(); addr_q.delete();
    tick(2);
    reset_n = 1'b1;
    wait_arb(1'b0, "arst");
    tick(2);
    check("arst_valid", word_valid, 0);
    check("arst_done", line_done, 1);
    check("arst_req", mem_req, 0);

    line_go(18'h00800, 3);
    wait_arb(1'b1, "vsup");
    tick(1);
    vdp_super = 1'b0; exp_q.delete(); addr_q.delete();
    tick(1);
    vdp_super = 1'b1;
    check("vsup_addr", mem_addr, 0);
    wait_arb(1'b0, "vsup");
    tick(2);
    check("vsup_valid", word_valid, 0);
    check("vsup_done", line_done, 1);

    for (int ln = 0; ln < 40; ln++) begin
      ack_lat = $urandom_range(1, 3);
      data_lat = $urandom_range(1, 4);
      a = ($urandom_range(0, 3) == 0) ? 18'h3FFF8 + 18'($urandom_range(0, 7)) : 18'($urandom);
      n = $urandom_range(0, 12);
      pop = ($urandom_range(0, 1) == 1);
      line_go(a, n);
      aborted = 1'b0;
      for (int c = 0; c < 300; c++) begin
        pop = ($urandom_range(0, 99) < 55);
        clear_underrun = ($urandom_range(0, 19) == 0);
        tick(1);
        if (line_done && !word_valid && !arb_busy) break;
        if ($urandom_range(0, 149) == 0) begin aborted = 1'b1; break; end
      end
      pop = 1'b0; clear_underrun = 1'b0;
      if (!aborted) drain("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
